// File: rtl/pjon_pad_pkg.sv
// Shared types and width constants for the PJON pad front end.
package pjon_pad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GUARD = 2'd2
  } pad_state_e;

  // Upper bounds of the supported parameter ranges; counters are sized from them.
  localparam int MaxSyncStages  = 4;
  localparam int MaxFilterLen   = 15;
  localparam int MaxGuardCycles = 15;

  localparam int FltCntW   = $clog2(MaxFilterLen + 1);
  localparam int GuardCntW = $clog2(MaxGuardCycles + 1);
  localparam int DriveCntW = $clog2(MaxSyncStages + 1);

endpackage

// File: rtl/pjon_pad_channel.sv
// One PJON pad channel: registered drive path, synchronised and glitch-filtered
// receive path, IDLE/DRIVE/GUARD turnaround FSM and single-wire collision check.
module pjon_pad_channel
  import pjon_pad_pkg::*;
#(
  parameter int SyncStages  = 2,
  parameter int FilterLen   = 3,
  parameter int GuardCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_data,
  input  logic       tx_en,
  input  logic       pad_sw,
  input  logic       pad_direct,
  input  logic       single_wire_en,
  input  logic       collision_clr,
  output logic       rx_data,
  output logic       pad_data,
  output logic       pad_en,
  output logic       collision,
  output logic       mode,
  output logic [1:0] state_dbg
);

  localparam logic [FltCntW-1:0]   FltLast     = FltCntW'(FilterLen - 1);
  localparam logic [GuardCntW-1:0] GuardLast   = GuardCntW'(GuardCycles - 1);
  localparam logic [DriveCntW-1:0] DriveSettle = DriveCntW'(SyncStages);

  pad_state_e            state, state_nxt;
  logic [GuardCntW-1:0]  guard_cnt, guard_cnt_nxt;
  logic [FltCntW-1:0]    flt_cnt;
  logic [DriveCntW-1:0]  drive_cnt;
  logic [SyncStages-1:0] mode_sync, rx_sync, tx_dly;
  logic                  rx_raw, rx_s, enter_idle, mismatch;

  assign rx_raw     = mode ? pad_sw : pad_direct;
  assign rx_s       = rx_sync[SyncStages-1];
  assign enter_idle = (state != ST_IDLE) && (state_nxt == ST_IDLE);
  assign state_dbg  = state;

  // tx_dly matches the loopback latency through the receive synchroniser, so in
  // a healthy single-wire bus both sides of the compare carry the same bit.
  assign mismatch = mode && (state == ST_DRIVE) && (drive_cnt == DriveSettle) &&
                    (rx_s != tx_dly[SyncStages-1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      guard_cnt <= '0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    guard_cnt_nxt = guard_cnt;
    case (state)
      ST_IDLE: begin
        if (pad_en) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (!pad_en) begin
          if (GuardCycles == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt     = ST_GUARD;
            guard_cnt_nxt = '0;
          end
        end
      end
      ST_GUARD: begin
        if (pad_en) begin
          state_nxt = ST_DRIVE;
        end else if (guard_cnt == GuardLast) begin
          state_nxt = ST_IDLE;
        end else begin
          guard_cnt_nxt = guard_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_data  <= 1'b0;
      pad_en    <= 1'b0;
      mode_sync <= '0;
      rx_sync   <= '0;
      tx_dly    <= '0;
      mode      <= 1'b0;
      rx_data   <= 1'b0;
      flt_cnt   <= '0;
      drive_cnt <= '0;
      collision <= 1'b0;
    end else begin
      pad_data  <= tx_data;
      pad_en    <= tx_en;
      mode_sync <= {mode_sync[SyncStages-2:0], single_wire_en};
      rx_sync   <= {rx_sync[SyncStages-2:0], rx_raw};
      tx_dly    <= {tx_dly[SyncStages-2:0], pad_data};

      // A mode change requested mid-transfer waits until the line is idle.
      if (state == ST_IDLE) mode <= mode_sync[SyncStages-1];

      // The filter is frozen through the guard window so our own turnaround
      // never shows up as received data.
      if (enter_idle) begin
        flt_cnt <= '0;
      end else if (state != ST_GUARD) begin
        if (rx_s != rx_data) begin
          if (flt_cnt == FltLast) begin
            rx_data <= rx_s;
            flt_cnt <= '0;
          end else begin
            flt_cnt <= flt_cnt + 1'b1;
          end
        end else begin
          flt_cnt <= '0;
        end
      end

      if (state == ST_DRIVE) begin
        if (drive_cnt != DriveSettle) drive_cnt <= drive_cnt + 1'b1;
      end else begin
        drive_cnt <= '0;
      end

      if (mismatch) collision <= 1'b1;
      else if (collision_clr) collision <= 1'b0;
    end
  end

endmodule

// File: rtl/pjon_pad_frontend.sv
// PJON pad front end: NumChannels independent pad channels side by side.
module pjon_pad_frontend #(
  parameter int NumChannels = 2,
  parameter int SyncStages  = 2,
  parameter int FilterLen   = 3,
  parameter int GuardCycles = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumChannels-1:0]   pjon_hw_o,
  input  logic [NumChannels-1:0]   pjon_hw_en_o,
  output logic [NumChannels-1:0]   pjon_hw_i,
  output logic [NumChannels-1:0]   pad_o,
  output logic [NumChannels-1:0]   pad_oe_o,
  input  logic [NumChannels-1:0]   pad_sw_i,
  input  logic [NumChannels-1:0]   pad_direct_i,
  input  logic [NumChannels-1:0]   single_wire_en_i,
  input  logic [NumChannels-1:0]   collision_clr_i,
  output logic [NumChannels-1:0]   collision_o,
  output logic [NumChannels-1:0]   mode_o,
  output logic [2*NumChannels-1:0] state_dbg_o
);

  for (genvar g = 0; g < NumChannels; g++) begin : gen_ch
    pjon_pad_channel #(
      .SyncStages (SyncStages),
      .FilterLen  (FilterLen),
      .GuardCycles(GuardCycles)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .tx_data       (pjon_hw_o[g]),
      .tx_en         (pjon_hw_en_o[g]),
      .pad_sw        (pad_sw_i[g]),
      .pad_direct    (pad_direct_i[g]),
      .single_wire_en(single_wire_en_i[g]),
      .collision_clr (collision_clr_i[g]),
      .rx_data       (pjon_hw_i[g]),
      .pad_data      (pad_o[g]),
      .pad_en        (pad_oe_o[g]),
      .collision     (collision_o[g]),
      .mode          (mode_o[g]),
      .state_dbg     (state_dbg_o[2*g +: 2])
    );
  end

endmodule

// File: tb/tb_pjon_pad_frontend.sv
// Bench for pjon_pad_frontend: random receive traffic against a window model,
// then directed turnaround, collision, mode-deferral and reset scenarios.
module tb_pjon_pad_frontend;
  import pjon_pad_pkg::*;

  localparam int NC = 2;
  localparam int SS = 2;
  localparam int FL = 3;
  localparam int GC = 4;
  localparam int W  = 5 * NC;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC-1:0]   pjon_hw_o = '0, pjon_hw_en_o = '0, pad_sw_i = '0, pad_direct_i = '0;
  logic [NC-1:0]   single_wire_en_i = '0, collision_clr_i = '0;
  logic [NC-1:0]   pjon_hw_i, pad_o, pad_oe_o, collision_o, mode_o;
  logic [2*NC-1:0] state_dbg_o;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  pjon_pad_frontend #(
    .NumChannels(NC), .SyncStages(SS), .FilterLen(FL), .GuardCycles(GC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pjon_hw_o(pjon_hw_o), .pjon_hw_en_o(pjon_hw_en_o), .pjon_hw_i(pjon_hw_i),
    .pad_o(pad_o), .pad_oe_o(pad_oe_o), .pad_sw_i(pad_sw_i), .pad_direct_i(pad_direct_i),
    .single_wire_en_i(single_wire_en_i), .collision_clr_i(collision_clr_i),
    .collision_o(collision_o), .mode_o(mode_o), .state_dbg_o(state_dbg_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] obs();
    return {mode_o, collision_o, pad_oe_o, pad_o, pjon_hw_i};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (obs() !== e) begin
          fails++;
          $display("FAIL sb_cycle: got %h, required %h", obs(), e);
        end
      end
    end
  end

  // Random receive traffic, both channels idle in direct mode. Reference: the
  // filtered level flips once the raw input, seen SS cycles late, has stayed
  // opposite to it for FL consecutive samples.
  task automatic random_phase(input int cycles);
    logic [NC-1:0] raw, tx, lvl;
    logic [NC-1:0] raw_hist[$];
    bit all_opp;
    raw = '0;
    lvl = '0;
    for (int k = 0; k < SS + FL; k++) raw_hist.push_back('0);
    for (int i = 0; i < cycles; i++) begin
      for (int ch = 0; ch < NC; ch++)
        if ($urandom_range(0, 2) == 0) raw[ch] = ~raw[ch];
      tx              = NC'($urandom);
      pad_direct_i    = raw;
      pjon_hw_o       = tx;
      pad_sw_i        = NC'($urandom);
      collision_clr_i = NC'($urandom);
      tick(1);
      raw_hist.push_front(raw);
      void'(raw_hist.pop_back());
      for (int ch = 0; ch < NC; ch++) begin
        all_opp = 1'b1;
        for (int j = 0; j < FL; j++)
          if (raw_hist[SS + j][ch] == lvl[ch]) all_opp = 1'b0;
        if (all_opp) lvl[ch] = ~lvl[ch];
      end
      exp_q.push_back({NC'(0), NC'(0), NC'(0), tx, lvl});
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin : stimulus
    bit any_high, found, held, reached;
    int lat;

    // reset state, with busy inputs
    pjon_hw_o = '1; pjon_hw_en_o = '1; pad_direct_i = '1; single_wire_en_i = '1;
    tick(4);
    check("rst_outputs", obs(), 0);
    check("rst_state", state_dbg_o, 0);
    pjon_hw_o = '0; pjon_hw_en_o = '0; pad_direct_i = '0; single_wire_en_i = '0;
    rst_n = 1'b1;
    tick(8);
    check("post_rst_outputs", obs(), 0);

    random_phase(300);
    pjon_hw_o = '0; pad_direct_i = '0; pad_sw_i = '0; collision_clr_i = '0;
    tick(8);

    // glitch rejection and filter latency, channel 0 direct
    pad_direct_i[0] = 1'b1;
    tick(2);
    pad_direct_i[0] = 1'b0;
    any_high = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (pjon_hw_i[0]) any_high = 1'b1;
    end
    check("glitch_2cyc", any_high, 0);
    pad_direct_i[0] = 1'b1;
    tick(3);
    pad_direct_i[0] = 1'b0;
    tick(1);
    check("pulse_before_5", pjon_hw_i[0], 0);
    tick(1);
    check("pulse_at_5", pjon_hw_i[0], 1);
    tick(8);

    // turnaround guard on channel 1
    pjon_hw_o[1] = 1'b1; pjon_hw_en_o[1] = 1'b1; pad_direct_i[1] = 1'b1;
    tick(10);
    check("ch1_rx_high", pjon_hw_i[1], 1);
    check("ch1_drive", state_dbg_o[3:2], ST_DRIVE);
    pjon_hw_en_o[1] = 1'b0; pad_direct_i[1] = 1'b0;
    tick(1);
    check("ch1_oe_fall", pad_oe_o[1], 0);
    tick(1);
    check("ch1_guard", state_dbg_o[3:2], ST_GUARD);
    tick(4);
    check("ch1_idle_after_guard", state_dbg_o[3:2], ST_IDLE);
    check("ch1_rx_held", pjon_hw_i[1], 1);
    tick(2);
    check("ch1_rx_still_held", pjon_hw_i[1], 1);
    tick(1);
    check("ch1_rx_resumed", pjon_hw_i[1], 0);
    pjon_hw_o[1] = 1'b0;
    tick(4);

    // collision detection on channel 0, single-wire
    single_wire_en_i[0] = 1'b1;
    tick(5);
    check("mode_sw", mode_o[0], 1);
    pad_sw_i[0] = 1'b0; pjon_hw_o[0] = 1'b1; pjon_hw_en_o[0] = 1'b1;
    found = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6 && !found; i++) begin
      tick(1);
      if (collision_o[0]) begin
        found = 1'b1;
        lat = i;
      end
    end
    check("col_set", found, 1);
    check("col_latency", lat, 5);
    tick(3);
    check("col_sticky", collision_o[0], 1);
    pad_sw_i[0] = 1'b1;
    tick(4);
    collision_clr_i[0] = 1'b1;
    tick(1);
    collision_clr_i[0] = 1'b0;
    check("col_cleared", collision_o[0], 0);
    tick(2);
    check("col_loopback_ok", collision_o[0], 0);
    pad_sw_i[0] = 1'b0;
    tick(4);
    check("col_reset", collision_o[0], 1);
    collision_clr_i[0] = 1'b1;
    tick(1);
    collision_clr_i[0] = 1'b0;
    check("col_set_wins", collision_o[0], 1);

    // deferred mode change
    pad_sw_i[0] = 1'b1;
    single_wire_en_i[0] = 1'b0;
    tick(6);
    check("mode_deferred", mode_o[0], 1);
    check("mode_still_drive", state_dbg_o[1:0], ST_DRIVE);
    pjon_hw_en_o[0] = 1'b0;
    held = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      tick(1);
      if (mode_o[0] !== 1'b1) held = 1'b0;
      if (state_dbg_o[1:0] == ST_IDLE) reached = 1'b1;
    end
    check("mode_held_till_idle", held, 1);
    check("mode_reach_idle", reached, 1);
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      tick(1);
      if (mode_o[0] == 1'b0) found = 1'b1;
    end
    check("mode_updated", found, 1);
    pad_sw_i[0] = 1'b0;
    tick(8);

    // asynchronous reset mid-drive
    pjon_hw_o[0] = 1'b1; pjon_hw_en_o[0] = 1'b1;
    tick(3);
    check("pre_rst_oe", pad_oe_o[0], 1);
    check("pre_rst_drive", state_dbg_o[1:0], ST_DRIVE);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_oe", pad_oe_o[0], 0);
    check("rst_async_all", obs(), 0);
    pjon_hw_o = '0; pjon_hw_en_o = '0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("rel_outputs", obs(), 0);
    check("rel_state", state_dbg_o, 0);
    pjon_hw_en_o[0] = 1'b1;
    tick(1);
    check("rel_new_drive", pad_oe_o[0], 1);
    pjon_hw_en_o[0] = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
